// File: rtl/ucode_pkg.sv
// Shared types and control-word field positions for the microcode sequencer.
// Stateless: constants and the FSM state encoding only.
package ucode_pkg;

    localparam int UPC_W  = 9;
    localparam int CTRL_W = 69;

    localparam logic [UPC_W-1:0] IRQ_UPC_DEFAULT = 9'h1F0;

    localparam int CTRL_LAST     = 68;
    localparam int CTRL_MEM      = 67;
    localparam int CTRL_CBPFX    = 66;
    localparam int CTRL_CONDEND  = 65;
    localparam int CTRL_HALT     = 64;
    localparam int CTRL_NEXT_MSB = 63;
    localparam int CTRL_NEXT_LSB = 55;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/ucode_sequencer.sv
// Drives the microcode ROM address and qualifies each control word; first exec_en is one cycle after fetch_ack.
// Stalls in place on mem_busy for MEM micro-ops; fetch_req is held until fetch_ack.
module ucode_sequencer
    import ucode_pkg::*;
#(
    parameter logic [UPC_W-1:0] IRQ_UPC = IRQ_UPC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              fetch_req,
    input  logic              fetch_ack,
    input  logic [7:0]        instr_data,
    output logic [UPC_W-1:0]  upc,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic              mem_busy,
    input  logic              cond_true,
    input  logic              ime,
    input  logic              irq_req,
    output logic              exec_en,
    output logic              instr_done,
    output logic              halted
);

    state_t           r_state;
    logic [UPC_W-1:0] r_upc;
    logic             r_cb_pending;
    logic             r_fetch_req;
    logic             r_halted;

    logic w_stall;
    logic w_exec;
    logic w_cond_exit;
    logic w_irq_take;
    logic w_ctrl_unused;

    assign w_stall     = ctrl[CTRL_MEM] & mem_busy;
    assign w_exec      = (r_state == EXEC) & ~w_stall;
    assign w_cond_exit = ctrl[CTRL_CONDEND] & ~cond_true;
    assign w_irq_take  = ime & irq_req;

    // Datapath payload bits are consumed by the datapath, not by the sequencer.
    assign w_ctrl_unused = ^ctrl[CTRL_NEXT_LSB-1:0];

    assign exec_en    = w_exec;
    assign instr_done = w_exec & ~ctrl[CTRL_CBPFX] &
                        (ctrl[CTRL_HALT] | ctrl[CTRL_LAST] | w_cond_exit);
    assign fetch_req  = r_fetch_req;
    assign upc        = r_upc;
    assign halted     = r_halted;

    // A FETCH cycle with fetch_req low is the entry cycle where a pending interrupt
    // may pre-empt the opcode fetch; a retire with no interrupt skips it so the
    // request rises right away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FETCH;
            r_upc        <= '0;
            r_cb_pending <= 1'b0;
            r_fetch_req  <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            unique case (r_state)
                FETCH: begin
                    if (!r_fetch_req) begin
                        if (w_irq_take) begin
                            r_upc   <= IRQ_UPC;
                            r_state <= EXEC;
                        end else begin
                            r_fetch_req <= 1'b1;
                        end
                    end else if (fetch_ack) begin
                        r_upc        <= {r_cb_pending, instr_data};
                        r_cb_pending <= 1'b0;
                        r_fetch_req  <= 1'b0;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (!w_stall) begin
                        if (ctrl[CTRL_CBPFX]) begin
                            r_cb_pending <= 1'b1;
                            r_fetch_req  <= 1'b1;
                            r_state      <= FETCH;
                        end else if (ctrl[CTRL_HALT]) begin
                            r_halted <= 1'b1;
                            r_state  <= HALT;
                        end else if (ctrl[CTRL_LAST] || w_cond_exit) begin
                            r_fetch_req <= ~w_irq_take;
                            r_state     <= FETCH;
                        end else begin
                            r_upc <= ctrl[CTRL_NEXT_MSB:CTRL_NEXT_LSB];
                        end
                    end
                end
                HALT: begin
                    if (irq_req) begin
                        r_halted    <= 1'b0;
                        r_fetch_req <= ~ime;
                        r_state     <= FETCH;
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer with a small behavioural microcode ROM.
module tb_ucode_sequencer;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic        fetch_ack;
    logic [7:0]  instr_data;
    logic [8:0]  upc;
    logic [68:0] ctrl;
    logic        mem_busy;
    logic        cond_true;
    logic        ime;
    logic        irq_req;
    logic        exec_en;
    logic        instr_done;
    logic        halted;

    int n_cmp;
    int n_err;

    logic [68:0] rom [0:511];

    assign ctrl = rom[upc];

    ucode_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_req  (fetch_req),
        .fetch_ack  (fetch_ack),
        .instr_data (instr_data),
        .upc        (upc),
        .ctrl       (ctrl),
        .mem_busy   (mem_busy),
        .cond_true  (cond_true),
        .ime        (ime),
        .irq_req    (irq_req),
        .exec_en    (exec_en),
        .instr_done (instr_done),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [68:0] mk(input logic last, input logic mem, input logic cb,
                                       input logic cnd, input logic hlt, input logic [8:0] nxt);
        logic [68:0] w;
        w      = '0;
        w[68]  = last;
        w[67]  = mem;
        w[66]  = cb;
        w[65]  = cnd;
        w[64]  = hlt;
        w[63:55] = nxt;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Checks every output: upc, fetch_req, exec_en, instr_done, halted.
    task automatic expect_out(input string tag, input logic [8:0] e_upc, input logic e_req,
                              input logic e_exec, input logic e_done, input logic e_halt);
        n_cmp++;
        assert (upc === e_upc) else begin
            n_err++;
            $error("FAIL %s.upc observed=%h expected=%h", tag, upc, e_upc);
        end
        cmp1({tag, ".fetch_req"}, fetch_req, e_req);
        cmp1({tag, ".exec_en"}, exec_en, e_exec);
        cmp1({tag, ".instr_done"}, instr_done, e_done);
        cmp1({tag, ".halted"}, halted, e_halt);
    endtask

    task automatic do_fetch(input logic [7:0] b);
        fetch_ack  = 1'b1;
        instr_data = b;
        tick();
        fetch_ack  = 1'b0;
        instr_data = 8'h00;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 512; i++) rom[i] = '0;
        rom[9'h000] = mk(1, 0, 0, 0, 0, 9'h000);
        rom[9'h0CB] = mk(0, 0, 1, 0, 0, 9'h000);
        rom[9'h137] = mk(1, 0, 0, 0, 0, 9'h000);
        rom[9'h010] = mk(0, 0, 0, 0, 0, 9'h150);
        rom[9'h150] = mk(0, 1, 0, 0, 0, 9'h151);
        rom[9'h151] = mk(1, 0, 0, 0, 0, 9'h000);
        rom[9'h020] = mk(0, 0, 0, 1, 0, 9'h160);
        rom[9'h160] = mk(1, 0, 0, 0, 0, 9'h000);
        rom[9'h076] = mk(0, 0, 0, 0, 1, 9'h000);
        rom[9'h1F0] = mk(1, 0, 0, 0, 0, 9'h000);
        rom[9'h030] = mk(1, 1, 0, 0, 0, 9'h000);

        rst_n      = 1'b0;
        fetch_ack  = 1'b0;
        instr_data = 8'h00;
        mem_busy   = 1'b0;
        cond_true  = 1'b0;
        ime        = 1'b0;
        irq_req    = 1'b0;
        #1;
        expect_out("reset", 9'h000, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        expect_out("fetch_entry", 9'h000, 1, 0, 0, 0);

        // Single-step instruction
        do_fetch(8'h00);
        expect_out("op00_exec", 9'h000, 0, 1, 1, 0);
        tick();
        expect_out("op00_refetch", 9'h000, 1, 0, 0, 0);

        // CB prefix page
        do_fetch(8'hCB);
        expect_out("cb_prefix", 9'h0CB, 0, 1, 0, 0);
        tick();
        expect_out("cb_refetch", 9'h0CB, 1, 0, 0, 0);
        do_fetch(8'h37);
        expect_out("cb37_exec", 9'h137, 0, 1, 1, 0);
        tick();
        expect_out("cb37_refetch", 9'h137, 1, 0, 0, 0);

        // Three-step instruction with a 2-cycle memory stall
        do_fetch(8'h10);
        expect_out("op10_s1", 9'h010, 0, 1, 0, 0);
        mem_busy = 1'b1;
        #1;
        expect_out("op10_s1_busy_ignored", 9'h010, 0, 1, 0, 0);
        tick();
        expect_out("op10_stall1", 9'h150, 0, 0, 0, 0);
        tick();
        expect_out("op10_stall2", 9'h150, 0, 0, 0, 0);
        mem_busy = 1'b0;
        #1;
        expect_out("op10_s2", 9'h150, 0, 1, 0, 0);
        tick();
        expect_out("op10_s3", 9'h151, 0, 1, 1, 0);
        tick();
        expect_out("op10_refetch", 9'h151, 1, 0, 0, 0);

        // Conditional early exit, then fall-through
        cond_true = 1'b0;
        do_fetch(8'h20);
        expect_out("condend_exit", 9'h020, 0, 1, 1, 0);
        tick();
        expect_out("condend_refetch", 9'h020, 1, 0, 0, 0);
        cond_true = 1'b1;
        do_fetch(8'h20);
        expect_out("condend_cont", 9'h020, 0, 1, 0, 0);
        tick();
        expect_out("condend_next", 9'h160, 0, 1, 1, 0);
        tick();
        expect_out("condend_refetch2", 9'h160, 1, 0, 0, 0);

        // HALT left by an interrupt with ime=1
        do_fetch(8'h76);
        expect_out("halt_exec", 9'h076, 0, 1, 1, 0);
        tick();
        expect_out("halted1", 9'h076, 0, 0, 0, 1);
        tick();
        expect_out("halted2", 9'h076, 0, 0, 0, 1);
        ime     = 1'b1;
        irq_req = 1'b1;
        tick();
        expect_out("halt_exit_ime", 9'h076, 0, 0, 0, 0);
        tick();
        expect_out("irq_entry", 9'h1F0, 0, 1, 1, 0);
        ime     = 1'b0;
        irq_req = 1'b0;
        tick();
        expect_out("irq_refetch", 9'h1F0, 1, 0, 0, 0);

        // HALT left by an interrupt with ime=0
        do_fetch(8'h76);
        expect_out("halt2_exec", 9'h076, 0, 1, 1, 0);
        tick();
        expect_out("halted3", 9'h076, 0, 0, 0, 1);
        irq_req = 1'b1;
        tick();
        expect_out("halt_exit_noime", 9'h076, 1, 0, 0, 0);
        irq_req = 1'b0;

        // fetch_ack and irq_req together: ack wins, irq at next FETCH entry
        ime     = 1'b1;
        irq_req = 1'b1;
        do_fetch(8'h00);
        expect_out("ack_beats_irq", 9'h000, 0, 1, 1, 0);
        tick();
        expect_out("irq_check_entry", 9'h000, 0, 0, 0, 0);
        tick();
        expect_out("irq_after_ack", 9'h1F0, 0, 1, 1, 0);
        ime     = 1'b0;
        irq_req = 1'b0;
        tick();
        expect_out("irq2_refetch", 9'h1F0, 1, 0, 0, 0);

        // Asynchronous reset during a stall and during a committing cycle
        mem_busy = 1'b1;
        do_fetch(8'h30);
        expect_out("op30_stall", 9'h030, 0, 0, 0, 0);
        tick();
        expect_out("op30_stall_hold", 9'h030, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        expect_out("async_rst_stall", 9'h000, 0, 0, 0, 0);
        rst_n    = 1'b1;
        mem_busy = 1'b0;
        tick();
        expect_out("post_rst_fetch", 9'h000, 1, 0, 0, 0);
        do_fetch(8'h30);
        expect_out("op30_exec", 9'h030, 0, 1, 1, 0);
        rst_n = 1'b0;
        #1;
        expect_out("async_rst_exec", 9'h000, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        expect_out("post_rst_fetch2", 9'h000, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
